iddrx8_word_aligner: RTL and testbench
======================================

Name: iddrx8_word_aligner

Overview:
- Word-alignment controller directly downstream of the 1:16 DDR gearbox (x8 input deserializer).
- Runs in the SCLK domain and consumes the gearbox's 16-bit parallel word.
- Compares each word against a training pattern and pulses the gearbox's ALIGNWD input to slip the word boundary until the pattern is found.
- Then asserts lock, forwards aligned data, and monitors for loss of alignment.

Parameters:
- TRAIN_PATTERN, 16'h00FF, expected word when aligned.
- MATCH_COUNT, 4, consecutive matching words required to declare lock (1..15).
- LOSS_COUNT, 8, consecutive mismatching words in LOCKED that drop lock (1..15).
- SETTLE_CYCLES, 6, SCLK cycles to wait after a slip before re-checking; covers gearbox pipeline latency (2..15).
- MAX_SLIPS, 16, slips attempted before declaring failure (1..31).

Ports:
- SCLK  in  1  slow parallel clock, same SCLK as the gearbox.
- RSTB  in  1  reset.
- align_en  in  1  level; 1 enables search and monitoring, 0 forces IDLE.
- rx_word  in  16  gearbox outputs Q15..Q0; Q0 is the earliest bit.
- alignwd  out  1  slip request to gearbox ALIGNWD; registered.
- locked  out  1  alignment achieved.
- fail  out  1  MAX_SLIPS exhausted without lock; sticky until RSTB or align_en=0.
- slip_count  out  5  slips issued in the current search.
- data_out  out  16  registered copy of rx_word.
- data_valid  out  1  data_out is aligned payload (equals locked, delayed with data_out).

Behaviour:
- Reset: RSTB is synchronous, active-high. On the SCLK rising edge with RSTB=1, all outputs go to 0, state=IDLE, and all counters clear. RSTB dominates every other input and applies mid-operation with no exception.
- Outputs are registered and change only on the SCLK rising edge.
- match = (rx_word == TRAIN_PATTERN), exact 16-bit compare.
- IDLE: all outputs 0 except data_out, which follows rx_word with 1-cycle latency. When align_en=1, go to CHECK with match_cnt=0 and slip_count=0.
- CHECK:
  - If match: match_cnt++. When match_cnt reaches MATCH_COUNT (including on the current word), go to LOCKED.
  - If mismatch: match_cnt=0. If slip_count==MAX_SLIPS, go to FAIL; else go to SLIP.
- SLIP: alignwd=1 for exactly one SCLK cycle, slip_count++ (saturating at 31), then go to WAIT. The gearbox detects the rising edge, so each 1-cycle pulse yields exactly one bit slip. alignwd is never high for 2 consecutive cycles.
- WAIT: count SETTLE_CYCLES cycles while ignoring rx_word, then go to CHECK with match_cnt=0.
- LOCKED:
  - locked=1, data_valid=1 (same cycle as locked), data_out=rx_word registered (1-cycle latency).
  - Mismatch: loss_cnt++. Match: loss_cnt=0.
  - When loss_cnt reaches LOSS_COUNT: locked=0, data_valid=0, go to CHECK with slip_count=0 and match_cnt=0. This re-search starts without slipping first.
- FAIL: fail=1, locked=0, no further slips. Stays in FAIL until align_en=0 (go to IDLE, fail clears next cycle) or RSTB.
- align_en deasserted in any state: next state IDLE.
  - If deasserted in SLIP, the alignwd pulse already registered completes its single cycle. No new pulse is issued.
  - locked, fail, and slip_count clear on the transition.
- slip_count holds its final value in LOCKED and FAIL for debug visibility.
- Lock on first check: if the pattern is already aligned, no slip is issued and locked rises MATCH_COUNT cycles after entering CHECK.

Test Plan:
- Pre-aligned: RSTB pulse, align_en=1, rx_word=16'h00FF constant -> alignwd never asserts; locked=1 on the 4th CHECK cycle; slip_count=0; data_out=16'h00FF.
- 3-bit offset: bench model rotates the pattern by 3, and each alignwd pulse reduces the rotation by 1 after a 4-cycle model latency -> exactly 3 one-cycle alignwd pulses at least 7 cycles apart; locked=1; slip_count=3.
- Never matches: rx_word=16'hAAAA -> 16 alignwd pulses; then fail=1, locked=0, alignwd stays 0. Dropping align_en gives fail=0 one cycle later.
- Loss of lock: lock on 16'h00FF, then drive 7 mismatches followed by 1 match -> locked stays 1. Then drive 8 mismatches -> locked=0 on the 8th; search restarts with slip_count=0.
- Reset mid-slip: assert RSTB in the cycle alignwd=1 -> next edge all outputs 0, state=IDLE. A 1-cycle glitch word during LOCKED does not drop lock.
- align_en toggled during WAIT -> returns to IDLE; no alignwd is issued while align_en=0.

Source files
------------

// File: rtl/iddrx8_word_aligner_if.sv
// iddrx8_word_aligner_if: gearbox-side bundle between the 1:16 deserializer and the word aligner
// Signals:
//   align_en   - enable search and monitoring (master -> slave)
//   rx_word    - gearbox parallel word, bit 0 earliest (master -> slave)
//   alignwd    - one-cycle slip request to the gearbox ALIGNWD (slave -> master)
//   locked     - alignment achieved (slave -> master)
//   fail       - slip budget exhausted without lock (slave -> master)
//   slip_count - slips issued in the current search (slave -> master)
//   data_out   - registered copy of rx_word (slave -> master)
//   data_valid - data_out is aligned payload (slave -> master)
interface iddrx8_word_aligner_if;
    logic        align_en;
    logic [15:0] rx_word;
    logic        alignwd;
    logic        locked;
    logic        fail;
    logic [4:0]  slip_count;
    logic [15:0] data_out;
    logic        data_valid;
    modport master (
        output align_en, rx_word,
        input  alignwd, locked, fail, slip_count, data_out, data_valid
    );
    modport slave (
        input  align_en, rx_word,
        output alignwd, locked, fail, slip_count, data_out, data_valid
    );
endinterface

// File: rtl/iddrx8_word_aligner.sv
// iddrx8_word_aligner: slips the x8 gearbox word boundary until the training pattern is seen, then locks and monitors
// Ports:
//   SCLK - slow parallel clock shared with the gearbox
//   RSTB - synchronous active-high reset
//   bus  - iddrx8_word_aligner_if.slave (align_en, rx_word in; alignwd, locked, fail,
//          slip_count, data_out, data_valid out; all outputs registered)
module iddrx8_word_aligner #(
    parameter logic [15:0] TRAIN_PATTERN = 16'h00FF,
    parameter int unsigned MATCH_COUNT   = 4,
    parameter int unsigned LOSS_COUNT    = 8,
    parameter int unsigned SETTLE_CYCLES = 6,
    parameter int unsigned MAX_SLIPS     = 16
) (
    input logic SCLK,
    input logic RSTB,
    iddrx8_word_aligner_if.slave bus
);
    localparam logic [3:0] MC = 4'(MATCH_COUNT);
    localparam logic [3:0] LC = 4'(LOSS_COUNT);
    localparam logic [3:0] SC = 4'(SETTLE_CYCLES - 1);
    localparam logic [4:0] MS = 5'(MAX_SLIPS);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_SLIP, S_WAIT, S_LOCKED, S_FAIL} state_t;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_match_cnt, w_match_nxt;
    logic [3:0]  r_loss_cnt, w_loss_nxt;
    logic [3:0]  r_wait_cnt, w_wait_nxt;
    logic [4:0]  r_slip_cnt, w_slip_nxt;
    logic        r_alignwd, r_locked, r_fail;
    logic        w_alignwd_nxt, w_locked_nxt, w_fail_nxt;
    logic [15:0] r_data;
    logic        w_match;

    assign w_match = bus.rx_word == TRAIN_PATTERN;

    always_ff @(posedge SCLK) begin
        if (RSTB) begin
            r_state     <= S_IDLE;
            r_match_cnt <= '0;
            r_loss_cnt  <= '0;
            r_wait_cnt  <= '0;
            r_slip_cnt  <= '0;
            r_alignwd   <= 1'b0;
            r_locked    <= 1'b0;
            r_fail      <= 1'b0;
            r_data      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_match_cnt <= w_match_nxt;
            r_loss_cnt  <= w_loss_nxt;
            r_wait_cnt  <= w_wait_nxt;
            r_slip_cnt  <= w_slip_nxt;
            r_alignwd   <= w_alignwd_nxt;
            r_locked    <= w_locked_nxt;
            r_fail      <= w_fail_nxt;
            r_data      <= bus.rx_word;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_match_nxt = r_match_cnt;
        w_loss_nxt  = r_loss_cnt;
        w_wait_nxt  = r_wait_cnt;
        w_slip_nxt  = r_slip_cnt;
        if (!bus.align_en) begin
            w_state_nxt = S_IDLE;
            w_match_nxt = '0;
            w_loss_nxt  = '0;
            w_wait_nxt  = '0;
            w_slip_nxt  = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_CHECK;
                    w_match_nxt = '0;
                    w_slip_nxt  = '0;
                end
                S_CHECK: begin
                    if (w_match) begin
                        w_match_nxt = r_match_cnt + 4'd1;
                        if (r_match_cnt + 4'd1 == MC) begin
                            w_state_nxt = S_LOCKED;
                            w_loss_nxt  = '0;
                        end
                    end else begin
                        w_match_nxt = '0;
                        w_state_nxt = (r_slip_cnt == MS) ? S_FAIL : S_SLIP;
                        // count the slip as the pulse is launched so slip_count and alignwd move together
                        if (r_slip_cnt != MS)
                            w_slip_nxt = (r_slip_cnt == 5'd31) ? r_slip_cnt : r_slip_cnt + 5'd1;
                    end
                end
                S_SLIP: begin
                    w_state_nxt = S_WAIT;
                    w_wait_nxt  = '0;
                end
                S_WAIT: begin
                    // rx_word is still the pre-slip word until the gearbox pipeline drains
                    w_state_nxt = (r_wait_cnt == SC) ? S_CHECK : S_WAIT;
                    w_wait_nxt  = r_wait_cnt + 4'd1;
                    w_match_nxt = '0;
                end
                S_LOCKED: begin
                    w_loss_nxt = w_match ? 4'd0 : r_loss_cnt + 4'd1;
                    if (!w_match && r_loss_cnt + 4'd1 == LC) begin
                        // re-search checks the current boundary before slipping again
                        w_state_nxt = S_CHECK;
                        w_loss_nxt  = '0;
                        w_match_nxt = '0;
                        w_slip_nxt  = '0;
                    end
                end
                S_FAIL: w_state_nxt = S_FAIL;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // outputs are decoded from the next state so they register on the same edge as the transition
    always_comb begin
        w_alignwd_nxt = w_state_nxt == S_SLIP;
        w_locked_nxt  = w_state_nxt == S_LOCKED;
        w_fail_nxt    = w_state_nxt == S_FAIL;
    end

    assign bus.alignwd    = r_alignwd;
    assign bus.locked     = r_locked;
    assign bus.fail       = r_fail;
    assign bus.slip_count = r_slip_cnt;
    assign bus.data_out   = r_data;
    assign bus.data_valid = r_locked;
endmodule

// File: tb/tb_iddrx8_word_aligner.sv
// tb_iddrx8_word_aligner: directed self-checking bench for the word aligner
module tb_iddrx8_word_aligner;
    logic SCLK = 1'b0;
    logic RSTB = 1'b1;
    int n_checks = 0;
    int n_errors = 0;

    iddrx8_word_aligner_if bus ();

    iddrx8_word_aligner dut (
        .SCLK (SCLK),
        .RSTB (RSTB),
        .bus  (bus.slave)
    );

    always #5 SCLK = ~SCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge SCLK);
        #1;
    endtask

    function automatic logic [15:0] rotl(input int r);
        logic [15:0] p;
        p = 16'h00FF;
        return (r == 0) ? p : ((p << r) | (p >> (16 - r)));
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_alignwd"}, bus.alignwd, 0);
        check({tag, "_locked"}, bus.locked, 0);
        check({tag, "_fail"}, bus.fail, 0);
        check({tag, "_slip"}, bus.slip_count, 0);
        check({tag, "_dout"}, bus.data_out, 0);
        check({tag, "_dvalid"}, bus.data_valid, 0);
    endtask

    initial begin
        int pulses, last, gap_min, b2b, rot, cnt, aw;
        int due[$];
        bus.align_en = 1'b0;
        bus.rx_word  = 16'h0000;
        step();
        step();
        check_all_zero("reset");

        // pre-aligned
        RSTB = 1'b0;
        bus.rx_word  = 16'h00FF;
        bus.align_en = 1'b1;
        aw = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            aw += int'(bus.alignwd);
        end
        check("prealign_not_yet", bus.locked, 0);
        step();
        aw += int'(bus.alignwd);
        check("prealign_locked", bus.locked, 1);
        check("prealign_no_slip", aw, 0);
        check("prealign_slipcnt", bus.slip_count, 0);
        check("prealign_dout", bus.data_out, 16'h00FF);
        check("prealign_dvalid", bus.data_valid, 1);

        // single glitch word while locked
        bus.rx_word = 16'h1234;
        step();
        bus.rx_word = 16'h00FF;
        step();
        check("glitch_keeps_lock", bus.locked, 1);

        // loss of lock: 7 misses then a hit keeps lock, 8 misses drop it
        bus.rx_word = 16'h1234;
        for (int i = 0; i < 7; i++) step();
        check("loss7_locked", bus.locked, 1);
        check("loss7_dout", bus.data_out, 16'h1234);
        bus.rx_word = 16'h00FF;
        step();
        check("loss_reset_locked", bus.locked, 1);
        bus.rx_word = 16'h1234;
        for (int i = 0; i < 7; i++) step();
        check("loss8_before", bus.locked, 1);
        step();
        check("loss8_unlocked", bus.locked, 0);
        check("loss8_dvalid", bus.data_valid, 0);
        check("loss8_slipcnt", bus.slip_count, 0);
        check("loss8_no_slip_yet", bus.alignwd, 0);
        step();
        check("research_slip", bus.alignwd, 1);
        check("research_slipcnt", bus.slip_count, 1);

        // 3-bit offset with a 4-cycle gearbox model latency
        bus.align_en = 1'b0;
        step();
        check("idle_slipcnt", bus.slip_count, 0);
        rot = 3;
        bus.rx_word = rotl(rot);
        bus.align_en = 1'b1;
        pulses = 0; last = -1000; gap_min = 1000; b2b = 0; aw = 0;
        for (int c = 0; c < 300 && !bus.locked; c++) begin
            step();
            if (bus.alignwd) begin
                if (aw != 0) b2b++;
                else begin
                    pulses++;
                    if (c - last < gap_min) gap_min = c - last;
                    last = c;
                end
                due.push_back(c + 4);
            end
            aw = int'(bus.alignwd);
            if (due.size() > 0 && due[0] == c) begin
                void'(due.pop_front());
                if (rot > 0) rot--;
            end
            bus.rx_word = rotl(rot);
        end
        check("rot3_locked", bus.locked, 1);
        check("rot3_pulses", pulses, 3);
        check("rot3_slipcnt", bus.slip_count, 3);
        check("rot3_gap_ge7", int'(gap_min >= 7), 1);
        check("rot3_no_b2b", b2b, 0);

        // never matches
        bus.align_en = 1'b0;
        step();
        bus.rx_word = 16'hAAAA;
        bus.align_en = 1'b1;
        pulses = 0;
        for (int c = 0; c < 400 && !bus.fail; c++) begin
            step();
            pulses += int'(bus.alignwd);
        end
        check("nomatch_fail", bus.fail, 1);
        check("nomatch_pulses", pulses, 16);
        check("nomatch_locked", bus.locked, 0);
        check("nomatch_slipcnt", bus.slip_count, 16);
        aw = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            aw += int'(bus.alignwd);
        end
        check("fail_no_slip", aw, 0);
        check("fail_sticky", bus.fail, 1);
        bus.align_en = 1'b0;
        step();
        check("fail_cleared", bus.fail, 0);
        check("fail_slipcnt_clr", bus.slip_count, 0);

        // reset in the cycle alignwd is high
        bus.align_en = 1'b1;
        cnt = 0;
        for (int c = 0; c < 50 && !bus.alignwd; c++) begin
            step();
            cnt++;
        end
        check("midslip_seen", bus.alignwd, 1);
        RSTB = 1'b1;
        bus.rx_word = 16'h0000;
        step();
        check_all_zero("midslip_rst");
        RSTB = 1'b0;
        bus.rx_word = 16'h00FF;
        cnt = 0;
        for (int c = 0; c < 50 && !bus.locked; c++) begin
            step();
            cnt++;
        end
        check("after_rst_lock_lat", cnt, 5);

        // align_en dropped during WAIT
        bus.align_en = 1'b0;
        step();
        bus.rx_word = 16'hAAAA;
        bus.align_en = 1'b1;
        for (int c = 0; c < 50 && !bus.alignwd; c++) step();
        check("wait_pulse_seen", bus.alignwd, 1);
        step();
        step();
        bus.align_en = 1'b0;
        aw = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            aw += int'(bus.alignwd);
        end
        check("wait_drop_no_slip", aw, 0);
        check("wait_drop_slipcnt", bus.slip_count, 0);
        check("wait_drop_locked", bus.locked, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
